// File: rtl/mem_arbiter_if.sv
// Bus bundle between the two requesters (fetch, data), the arbiter and the
// single memory port. The arbiter uses the master modport; the requesters and
// memory model together use the slave modport.
interface mem_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          if_ack;
  logic [DW-1:0] if_rdata;

  logic          d_req;
  logic          d_we;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic          d_ack;
  logic [DW-1:0] d_rdata;

  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          mem_valid;

  modport master (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_valid,
    output if_ack, if_rdata, d_ack, d_rdata, mem_req, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata, mem_valid,
    input  if_ack, if_rdata, d_ack, d_rdata, mem_req, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one memory port between instruction fetch and
// data load/store, one outstanding transaction at a time.
// Optional wait timeout: define MEM_TIMEOUT_EN to add the abort counter and
// the err_o port.
//
// state     | meaning
// ----------+---------------------------------------------------------
// ST_IDLE   | no transaction; sample requests and grant one
// ST_WAIT   | mem_req high, waiting for mem_valid (or timeout)
// ST_RESP   | one-cycle ack to the owner, then back to IDLE
module mem_arbiter #(
  parameter int AW             = 32,
  parameter int DW             = 32,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic          clk,
  input  logic          rst,
  mem_arbiter_if.master bus,
  output logic          busy_o
`ifdef MEM_TIMEOUT_EN
  ,
  output logic          err_o
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("mem_arbiter: TIMEOUT_CYCLES must be at least 1");
  end

  state_t        state_q, state_d;
  logic          grant_v;       // a grant happens at the next edge
  logic          grant_d;       // 1 = data path wins, 0 = fetch wins
  logic          owner_d_q;     // owner of the transaction in flight
  logic          last_d_q;      // last grant went to the data path
  logic [AW-1:0] mem_addr_q;
  logic          mem_we_q;
  logic [DW-1:0] mem_wdata_q;
  logic [DW-1:0] if_rdata_q;
  logic [DW-1:0] d_rdata_q;

`ifdef MEM_TIMEOUT_EN
  localparam int TMR_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(TIMEOUT_CYCLES - 1);

  logic [TMR_W-1:0] tmr_q;      // down-counter, zero on the last allowed WAIT cycle
  logic             tmo_q;      // current transaction was aborted by timeout
  logic             tmo_v;
`endif

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next-state and grant decision; on a tie the requester not granted last wins.
  always_comb begin
    state_d = state_q;
    grant_v = 1'b0;
    grant_d = 1'b0;
`ifdef MEM_TIMEOUT_EN
    tmo_v   = 1'b0;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (bus.if_req || bus.d_req) begin
          grant_v = 1'b1;
          grant_d = bus.d_req && (!bus.if_req || !last_d_q);
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (bus.mem_valid) begin
          state_d = ST_RESP;
        end
`ifdef MEM_TIMEOUT_EN
        else if (tmr_q == '0) begin
          tmo_v   = 1'b1;
          state_d = ST_RESP;
        end
`endif
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs decoded from state; acks only in RESP, so they can never overlap.
  always_comb begin
    bus.mem_req = (state_q == ST_WAIT);
    bus.if_ack  = (state_q == ST_RESP) && !owner_d_q;
    bus.d_ack   = (state_q == ST_RESP) && owner_d_q;
    busy_o      = (state_q != ST_IDLE);
`ifdef MEM_TIMEOUT_EN
    err_o       = (state_q == ST_RESP) && tmo_q;
`endif
  end

  // Latch the winning request on grant and capture read data into the owner's register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner_d_q   <= 1'b0;
      last_d_q    <= 1'b1;
      mem_addr_q  <= '0;
      mem_we_q    <= 1'b0;
      mem_wdata_q <= '0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
    end else begin
      if (grant_v) begin
        owner_d_q   <= grant_d;
        last_d_q    <= grant_d;
        mem_addr_q  <= grant_d ? bus.d_addr : bus.if_addr;
        mem_we_q    <= grant_d && bus.d_we;
        mem_wdata_q <= grant_d ? bus.d_wdata : '0;
      end
      if (state_q == ST_WAIT && bus.mem_valid) begin
        if (owner_d_q) d_rdata_q  <= bus.mem_rdata;
        else           if_rdata_q <= bus.mem_rdata;
      end
`ifdef MEM_TIMEOUT_EN
      else if (tmo_v) begin
        if (owner_d_q) d_rdata_q  <= '0;
        else           if_rdata_q <= '0;
      end
`endif
    end
  end

`ifdef MEM_TIMEOUT_EN
  // Wait timer reloads on every grant and counts down through WAIT.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tmr_q <= '0;
      tmo_q <= 1'b0;
    end else if (grant_v) begin
      tmr_q <= TMR_LOAD;
      tmo_q <= 1'b0;
    end else begin
      if (state_q == ST_WAIT && tmr_q != '0) tmr_q <= tmr_q - 1'b1;
      if (tmo_v) tmo_q <= 1'b1;
    end
  end
`endif

  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.d_rdata   = d_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios followed by random
// request mixes, checked against a transaction-level model of the arbiter.
module tb_mem_arbiter;
  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int TMO = 8;

  logic clk = 1'b0;
  logic rst;
  logic busy;
`ifdef MEM_TIMEOUT_EN
  logic err;
`endif

  mem_arbiter_if #(.AW(AW), .DW(DW)) bus ();

  mem_arbiter #(.AW(AW), .DW(DW), .TIMEOUT_CYCLES(TMO)) dut (
    .clk    (clk),
    .rst    (rst),
    .bus    (bus),
    .busy_o (busy)
`ifdef MEM_TIMEOUT_EN
    ,
    .err_o  (err)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // transaction-level model state
  bit          m_last_d;
  logic [31:0] m_if_rdata;
  logic [31:0] m_d_rdata;
  bit          m_d_known;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic model_reset();
    m_last_d   = 1'b1;
    m_if_rdata = '0;
    m_d_rdata  = '0;
    m_d_known  = 1'b1;
  endtask

  // One complete transaction; called in an IDLE cycle with the requests set up.
  task automatic txn(input int delay, input logic [31:0] rd, input bit resp_glitch,
                     output bit who_d);
    bit          exp_d;
    bit          exp_we;
    logic [31:0] exp_addr;
    logic [31:0] exp_wdata;
    bit          got;
    exp_d     = bus.d_req && (!bus.if_req || !m_last_d);
    exp_addr  = exp_d ? bus.d_addr : bus.if_addr;
    exp_we    = exp_d && bus.d_we;
    exp_wdata = bus.d_wdata;
    who_d     = 1'b0;
    got       = 1'b0;
    for (int i = 0; i < 8 && !got; i++) begin
      step();
      got = bus.mem_req;
    end
    check("mem_req_start", {63'd0, got}, 64'd1);
    if (!got) return;
    check("mem_addr", bus.mem_addr, exp_addr);
    check("mem_we", bus.mem_we, exp_we);
    if (exp_we) check("mem_wdata", bus.mem_wdata, exp_wdata);
    for (int i = 0; i < delay; i++) begin
      check("ack_early", {bus.if_ack, bus.d_ack}, 64'd0);
      step();
      check("mem_req_hold", bus.mem_req, 1);
      check("mem_addr_hold", bus.mem_addr, exp_addr);
    end
    bus.mem_valid = 1'b1;
    bus.mem_rdata = rd;
    step();
    if (resp_glitch) bus.mem_rdata = ~rd;
    else             bus.mem_valid = 1'b0;
    who_d = bus.d_ack;
    check("if_ack", bus.if_ack, !exp_d);
    check("d_ack", bus.d_ack, exp_d);
    check("mem_req_resp", bus.mem_req, 0);
    if (!exp_d)       check("if_rdata", bus.if_rdata, rd);
    else if (!exp_we) check("d_rdata", bus.d_rdata, rd);
    m_last_d = exp_d;
    if (!exp_d) m_if_rdata = rd;
    else if (exp_we) m_d_known = 1'b0;
    else begin
      m_d_rdata = rd;
      m_d_known = 1'b1;
    end
    if (exp_d) bus.d_req  = 1'b0;
    else       bus.if_req = 1'b0;
    step();
    bus.mem_valid = 1'b0;
    check("ack_one_cycle", {bus.if_ack, bus.d_ack}, 64'd0);
    check("busy_idle", busy, 0);
    check("if_rdata_hold", bus.if_rdata, m_if_rdata);
    if (m_d_known) check("d_rdata_hold", bus.d_rdata, m_d_rdata);
  endtask

  initial begin
    bit who;
    bit order[4];
    bit got;
    rst           = 1'b1;
    bus.if_req    = 1'b0;
    bus.if_addr   = '0;
    bus.d_req     = 1'b0;
    bus.d_we      = 1'b0;
    bus.d_addr    = '0;
    bus.d_wdata   = '0;
    bus.mem_rdata = '0;
    bus.mem_valid = 1'b0;
    model_reset();
    step();
    step();
    check("rst_busy", busy, 0);
    check("rst_mem_req", bus.mem_req, 0);
    check("rst_mem_we", bus.mem_we, 0);
    check("rst_mem_addr", bus.mem_addr, 0);
    check("rst_mem_wdata", bus.mem_wdata, 0);
    check("rst_acks", {bus.if_ack, bus.d_ack}, 64'd0);
    check("rst_if_rdata", bus.if_rdata, 0);
    check("rst_d_rdata", bus.d_rdata, 0);
`ifdef MEM_TIMEOUT_EN
    check("rst_err", err, 0);
`endif
    rst = 1'b0;
    step();

    // fetch only, memory answers after 2 extra cycles
    bus.if_req  = 1'b1;
    bus.if_addr = 32'h100;
    txn(2, 32'hDEADBEEF, 1'b0, who);
    check("fetch_only_who", who, 0);

    // store, answer after 1 cycle
    bus.d_req   = 1'b1;
    bus.d_we    = 1'b1;
    bus.d_addr  = 32'h40;
    bus.d_wdata = 32'h12345678;
    txn(1, 32'h0BADF00D, 1'b0, who);
    check("store_who", who, 1);

    // both held: alternation I, D, I, D
    for (int t = 0; t < 4; t++) begin
      if (!bus.if_req) begin
        bus.if_req  = 1'b1;
        bus.if_addr = $urandom;
      end
      if (!bus.d_req) begin
        bus.d_req   = 1'b1;
        bus.d_we    = 1'($urandom_range(0, 1));
        bus.d_addr  = $urandom;
        bus.d_wdata = $urandom;
      end
      txn(t, $urandom, 1'b0, who);
      order[t] = who;
    end
    check("rr_order0", order[0], 0);
    check("rr_order1", order[1], 1);
    check("rr_order2", order[2], 0);
    check("rr_order3", order[3], 1);
    // drain the leftover fetch request
    txn(0, 32'hA5A5A5A5, 1'b0, who);

    // stray mem_valid in IDLE
    bus.mem_valid = 1'b1;
    bus.mem_rdata = 32'hBAD0BAD0;
    step();
    bus.mem_valid = 1'b0;
    check("idle_valid_busy", busy, 0);
    check("idle_valid_acks", {bus.if_ack, bus.d_ack}, 64'd0);
    step();
    check("idle_valid_if_rdata", bus.if_rdata, m_if_rdata);
    check("idle_valid_acks2", {bus.if_ack, bus.d_ack}, 64'd0);

    // stray mem_valid during RESP must not overwrite captured data
    bus.if_req  = 1'b1;
    bus.if_addr = 32'h200;
    txn(0, 32'h13572468, 1'b1, who);

    // reset while in WAIT, then a late response
    bus.if_req  = 1'b1;
    bus.if_addr = 32'h300;
    got = 1'b0;
    for (int i = 0; i < 8 && !got; i++) begin
      step();
      got = bus.mem_req;
    end
    check("rst_wait_reached", {63'd0, got}, 64'd1);
    rst = 1'b1;
    #1;
    check("async_rst_mem_req", bus.mem_req, 0);
    check("async_rst_busy", busy, 0);
    check("async_rst_mem_addr", bus.mem_addr, 0);
    check("async_rst_if_rdata", bus.if_rdata, 0);
    check("async_rst_acks", {bus.if_ack, bus.d_ack}, 64'd0);
    model_reset();
    bus.if_req = 1'b0;
    step();
    rst = 1'b0;
    bus.mem_valid = 1'b1;
    bus.mem_rdata = 32'hFEEDFACE;
    step();
    bus.mem_valid = 1'b0;
    check("late_valid_acks", {bus.if_ack, bus.d_ack}, 64'd0);
    check("late_valid_busy", busy, 0);
    step();
    check("late_valid_acks2", {bus.if_ack, bus.d_ack}, 64'd0);
    check("late_valid_if_rdata", bus.if_rdata, 0);
    // first tie after reset goes to fetch
    bus.if_req  = 1'b1;
    bus.if_addr = 32'h400;
    bus.d_req   = 1'b1;
    bus.d_we    = 1'b0;
    bus.d_addr  = 32'h500;
    txn(1, 32'h11112222, 1'b0, who);
    check("tie_after_rst", who, 0);
    txn(0, 32'h33334444, 1'b0, who);
    check("tie_after_rst_next", who, 1);

    // random request mixes
    for (int t = 0; t < 25; t++) begin
      if (!bus.if_req && $urandom_range(0, 1) == 1) begin
        bus.if_req  = 1'b1;
        bus.if_addr = $urandom;
      end
      if (!bus.d_req && $urandom_range(0, 1) == 1) begin
        bus.d_req   = 1'b1;
        bus.d_we    = 1'($urandom_range(0, 1));
        bus.d_addr  = $urandom;
        bus.d_wdata = $urandom;
      end
      if (!bus.if_req && !bus.d_req) begin
        bus.if_req  = 1'b1;
        bus.if_addr = $urandom;
      end
      txn($urandom_range(0, 4), $urandom, $urandom_range(0, 3) == 0, who);
    end
    for (int t = 0; t < 2; t++) begin
      if (bus.if_req || bus.d_req) txn(0, $urandom, 1'b0, who);
    end

    // memory never answers
    bus.d_req   = 1'b1;
    bus.d_we    = 1'b0;
    bus.d_addr  = 32'h800;
`ifdef MEM_TIMEOUT_EN
    begin
      int n;
      n = 0;
      step();
      while (bus.mem_req && n < 20) begin
        n++;
        step();
      end
      check("tmo_wait_cycles", n, TMO);
      check("tmo_d_ack", bus.d_ack, 1);
      check("tmo_err", err, 1);
      check("tmo_d_rdata", bus.d_rdata, 0);
      bus.d_req = 1'b0;
      step();
      check("tmo_err_pulse", err, 0);
      check("tmo_ack_pulse", bus.d_ack, 0);
    end
`else
    for (int i = 0; i < 101; i++) step();
    check("no_tmo_mem_req", bus.mem_req, 1);
    check("no_tmo_busy", busy, 1);
    check("no_tmo_acks", {bus.if_ack, bus.d_ack}, 64'd0);
    rst = 1'b1;
    bus.d_req = 1'b0;
    step();
    rst = 1'b0;
    step();
    check("no_tmo_recover", busy, 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
